// File: rtl/tspi_pkg.sv
// Shared trit encodings, FSM state encoding and trit helpers for the ternary SPI master.
package tspi_pkg;

   localparam logic [1:0] ZERO    = 2'b00;
   localparam logic [1:0] PLUS    = 2'b01;
   localparam logic [1:0] MINUS   = 2'b10;
   localparam logic [1:0] INVALID = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SETUP,
      SAMPLE,
      TRAIL,
      DONE
   } state_t;

   // Returns {err, trit}: an invalid pair is replaced by ZERO and flagged.
   function automatic logic [2:0] trit_sanitize(input logic [1:0] t);
      return (t == INVALID) ? {1'b1, ZERO} : {1'b0, t};
   endfunction

   // Outgoing trits never carry the invalid pair onto the wire.
   function automatic logic [1:0] trit_tx(input logic [1:0] t);
      return (t == INVALID) ? ZERO : t;
   endfunction

endpackage

// File: rtl/tspi_clkdiv.sv
// Half-period divider: counts CLKDIV cycles and pulses tick on the last one.
module tspi_clkdiv #(
   parameter int CLKDIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   output logic tick_o
);

   localparam int CW = $clog2(CLKDIV + 1);
   localparam logic [CW-1:0] TERM = CW'(CLKDIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == TERM);

   // Restart on request or after each terminal count so every state gets a fresh period.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (start_i || tick_o) begin
         cnt_d = '0;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tspi_master.sv
// Balanced-ternary serial master: shifts a TRITS-wide word out on O_mosi while
// sampling the same number of trits from I_miso, framed by O_cs_n and O_sck.
module tspi_master
   import tspi_pkg::*;
#(
   parameter int TRITS  = 6,
   parameter int CLKDIV = 4
) (
   input  logic                 I_clk,
   input  logic                 I_rst_n,
   input  logic [2*TRITS-1:0]   I_tx_data,
   input  logic                 I_tx_valid,
   output logic                 O_tx_ready,
   output logic [2*TRITS-1:0]   O_rx_data,
   output logic                 O_rx_valid,
   output logic                 O_rx_err,
   output logic [1:0]           O_mosi,
   output logic [1:0]           O_sck,
   output logic                 O_cs_n,
   input  logic [1:0]           I_miso
);

   localparam int TW = $clog2(TRITS + 1);
   localparam logic [TW-1:0] LAST_TRIT = TW'(TRITS - 1);

   state_t               state_q;
   logic [2*TRITS-1:0]   tx_q;
   logic [2*TRITS-1:0]   rx_sh_q;
   logic [TW-1:0]        trit_q;
   logic                 err_q;
   logic [1:0]           mosi_q;
   logic [1:0]           sck_q;
   logic                 cs_n_q;
   logic                 rx_valid_q;
   logic                 rx_err_q;
   logic [2*TRITS-1:0]   rx_data_q;

   logic [2*TRITS-1:0]   tx_shift_d;
   logic [2*TRITS-1:0]   rx_shift_d;
   logic [2:0]           miso_san;
   logic                 div_start;
   logic                 div_tick;

   assign O_tx_ready = (state_q == IDLE) & I_rst_n;
   assign O_rx_data  = rx_data_q;
   assign O_rx_valid = rx_valid_q;
   assign O_rx_err   = rx_err_q;
   assign O_mosi     = mosi_q;
   assign O_sck      = sck_q;
   assign O_cs_n     = cs_n_q;

   assign miso_san = trit_sanitize(I_miso);

   // Timed states change on the divider tick; IDLE and DONE hold the divider at zero
   // so the first timed state after them always starts a full period.
   assign div_start = (state_q == IDLE) || (state_q == DONE);

   // Transmit shifts MS-trit out first; receive shifts new trits in at the LS end.
   if (TRITS > 1) begin : g_shift_wide
      assign tx_shift_d = {tx_q[2*TRITS-3:0], ZERO};
      assign rx_shift_d = {rx_sh_q[2*TRITS-3:0], miso_san[1:0]};
   end else begin : g_shift_single
      assign tx_shift_d = ZERO;
      assign rx_shift_d = miso_san[1:0];
   end

   tspi_clkdiv #(
      .CLKDIV (CLKDIV)
   ) u_clkdiv (
      .clk_i   (I_clk),
      .rst_ni  (I_rst_n),
      .start_i (div_start),
      .tick_o  (div_tick)
   );

   // Transfer FSM; every output is set on the edge that enters the state it belongs to.
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         state_q    <= IDLE;
         tx_q       <= '0;
         rx_sh_q    <= '0;
         trit_q     <= '0;
         err_q      <= 1'b0;
         mosi_q     <= ZERO;
         sck_q      <= ZERO;
         cs_n_q     <= 1'b1;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (I_tx_valid) begin
                  state_q <= LEAD;
                  tx_q    <= I_tx_data;
                  mosi_q  <= trit_tx(I_tx_data[2*TRITS-1 -: 2]);
                  cs_n_q  <= 1'b0;
                  sck_q   <= ZERO;
                  err_q   <= 1'b0;
                  trit_q  <= '0;
               end
            end
            LEAD: begin
               if (div_tick) begin
                  state_q <= SETUP;
                  sck_q   <= MINUS;
                  mosi_q  <= trit_tx(tx_q[2*TRITS-1 -: 2]);
               end
            end
            SETUP: begin
               if (div_tick) begin
                  state_q <= SAMPLE;
                  sck_q   <= PLUS;
                  rx_sh_q <= rx_shift_d;
                  err_q   <= err_q | miso_san[2];
               end
            end
            SAMPLE: begin
               if (div_tick) begin
                  if (trit_q == LAST_TRIT) begin
                     state_q <= TRAIL;
                     sck_q   <= ZERO;
                     mosi_q  <= ZERO;
                     trit_q  <= '0;
                  end else begin
                     state_q <= SETUP;
                     sck_q   <= MINUS;
                     tx_q    <= tx_shift_d;
                     mosi_q  <= trit_tx(tx_shift_d[2*TRITS-1 -: 2]);
                     trit_q  <= trit_q + 1'b1;
                  end
               end
            end
            TRAIL: begin
               if (div_tick) begin
                  state_q    <= DONE;
                  cs_n_q     <= 1'b1;
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= rx_sh_q;
                  rx_err_q   <= err_q;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tspi_master.sv
// Bench for tspi_master: two instances (TRITS=3/CLKDIV=2 and TRITS=1/CLKDIV=1)
// driven from a vector table, hand sequences and random words against a cycle model.
module tb_tspi_master;

   logic       clk;
   logic       rst_n;

   logic [5:0] tx0;
   logic       v0;
   logic       rdy0;
   logic [5:0] rx0;
   logic       rxv0;
   logic       rxe0;
   logic [1:0] mosi0;
   logic [1:0] sck0;
   logic       cs0;
   logic [1:0] miso0;

   logic [1:0] tx1;
   logic       v1;
   logic       rdy1;
   logic [1:0] rx1;
   logic       rxv1;
   logic       rxe1;
   logic [1:0] mosi1;
   logic [1:0] sck1;
   logic       cs1;
   logic [1:0] miso1;

   logic       bad;
   logic       use_const;
   logic [1:0] const_miso;

   int ntests = 0;
   int nfail  = 0;

   assign miso0 = bad ? 2'b11 : (use_const ? const_miso : mosi0);
   assign miso1 = bad ? 2'b11 : (use_const ? const_miso : mosi1);

   tspi_master #(.TRITS(3), .CLKDIV(2)) dut0 (
      .I_clk(clk), .I_rst_n(rst_n), .I_tx_data(tx0), .I_tx_valid(v0),
      .O_tx_ready(rdy0), .O_rx_data(rx0), .O_rx_valid(rxv0), .O_rx_err(rxe0),
      .O_mosi(mosi0), .O_sck(sck0), .O_cs_n(cs0), .I_miso(miso0)
   );

   tspi_master #(.TRITS(1), .CLKDIV(1)) dut1 (
      .I_clk(clk), .I_rst_n(rst_n), .I_tx_data(tx1), .I_tx_valid(v1),
      .O_tx_ready(rdy1), .O_rx_data(rx1), .O_rx_valid(rxv1), .O_rx_err(rxe1),
      .O_mosi(mosi1), .O_sck(sck1), .O_cs_n(cs1), .I_miso(miso1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int         sel;
      logic [5:0] tx;
      int         bad_k;
      logic       uc;
      logic [1:0] cmiso;
      logic [5:0] exp_rx;
      logic       exp_err;
      string      name;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] act_wave(input int sel);
      return (sel != 0) ? {cs1, sck1, mosi1} : {cs0, sck0, mosi0};
   endfunction
   function automatic logic get_rdy(input int sel);
      return (sel != 0) ? rdy1 : rdy0;
   endfunction
   function automatic logic get_rxv(input int sel);
      return (sel != 0) ? rxv1 : rxv0;
   endfunction
   function automatic logic get_rxe(input int sel);
      return (sel != 0) ? rxe1 : rxe0;
   endfunction
   function automatic logic [5:0] get_rx(input int sel);
      return (sel != 0) ? {4'b0000, rx1} : rx0;
   endfunction

   task automatic set_tx(input int sel, input logic v, input logic [5:0] d);
      if (sel != 0) begin
         v1  = v;
         tx1 = d[1:0];
      end else begin
         v0  = v;
         tx0 = d;
      end
   endtask

   // Trit k of a word as it must appear on the wire (k=0 is sent first).
   function automatic logic [1:0] wire_trit(input int T, input logic [5:0] w, input int k);
      logic [1:0] t;
      t = w[2*(T-1-k) +: 2];
      return (t == 2'b11) ? 2'b00 : t;
   endfunction

   // Expected {cs_n, sck, mosi} in cycle n after the accepting edge.
   function automatic logic [4:0] exp_wave(input int T, input int C, input logic [5:0] w, input int n);
      int m;
      int k;
      if (n < C) return {1'b0, 2'b00, wire_trit(T, w, 0)};
      if (n < C + 2*T*C) begin
         m = n - C;
         k = m / (2*C);
         return {1'b0, ((m % (2*C)) < C) ? 2'b10 : 2'b01, wire_trit(T, w, k)};
      end
      if (n < C*(2*T+2)) return 5'b0_00_00;
      return 5'b1_00_00;
   endfunction

   // Expected received word and error flag from what the peripheral presents per trit.
   task automatic model_rx(input int T, input logic [5:0] w, input int bk, input logic uc,
                           input logic [1:0] cv, output logic [5:0] rx, output logic err);
      logic [1:0] v;
      rx  = '0;
      err = 1'b0;
      for (int k = 0; k < T; k++) begin
         if (k == bk)     v = 2'b11;
         else if (uc)     v = cv;
         else             v = wire_trit(T, w, k);
         if (v == 2'b11) begin
            err = 1'b1;
            v   = 2'b00;
         end
         rx = {rx[3:0], v};
      end
   endtask

   task automatic run_word(input int sel, input logic [5:0] word, input int bad_k,
                           input logic [5:0] exp_rx, input logic exp_err,
                           input bit hold, input logic [5:0] hold_word, input bit noise,
                           input string name, output int waited);
      int T;
      int C;
      int D;
      int wave_err;
      int first_bad;
      int cs_low;
      logic [5:0]  rx_at_d;
      logic        err_at_d;
      logic [4:0]  ew;
      logic [31:0] r;
      logic        mism;
      T = (sel != 0) ? 1 : 3;
      C = (sel != 0) ? 1 : 2;
      D = C*(2*T+2);
      waited = 0;
      while (!get_rdy(sel) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check({name, "_ready"}, 32'(get_rdy(sel)), 32'd1);
      if (!get_rdy(sel)) return;
      set_tx(sel, 1'b1, word);
      @(posedge clk);
      #1;
      if (hold) set_tx(sel, 1'b1, hold_word);
      else      set_tx(sel, 1'b0, 6'd0);
      wave_err  = 0;
      first_bad = -1;
      cs_low    = 0;
      rx_at_d   = '0;
      err_at_d  = 1'b0;
      for (int n = 0; n <= D; n++) begin
         @(negedge clk);
         ew   = exp_wave(T, C, word, n);
         mism = (act_wave(sel) !== ew) || (get_rxv(sel) !== (n == D)) || (get_rdy(sel) !== 1'b0);
         if (mism) begin
            wave_err++;
            if (first_bad < 0) first_bad = n;
         end
         if (act_wave(sel)[4] == 1'b0) cs_low++;
         if (n == D) begin
            rx_at_d  = get_rx(sel);
            err_at_d = get_rxe(sel);
         end
         bad = (bad_k >= 0) && (n == C*(2*bad_k+2) - 1);
         if (hold) begin
            set_tx(sel, 1'b1, hold_word);
         end else if (noise && n < D) begin
            r = $urandom;
            set_tx(sel, r[6], r[5:0]);
         end else begin
            set_tx(sel, 1'b0, 6'd0);
         end
      end
      bad = 1'b0;
      check({name, "_wave_bad_cycles"}, 32'(wave_err), 32'd0);
      if (wave_err != 0) $display("  first deviating cycle %0d", first_bad);
      check({name, "_rx_data"}, 32'(rx_at_d), 32'(exp_rx));
      check({name, "_rx_err"}, 32'(err_at_d), 32'(exp_err));
      check({name, "_cs_low_cycles"}, 32'(cs_low), 32'(D));
      @(negedge clk);
      check({name, "_after_done"}, {28'd0, get_rdy(sel), get_rxv(sel), act_wave(sel)[4], |act_wave(sel)[3:2]},
            32'b1010);
      if (!hold) set_tx(sel, 1'b0, 6'd0);
   endtask

   vec_t vecs[$];

   initial begin
      int          waited;
      logic [31:0] r;
      logic [5:0]  w;
      int          bk;
      logic [5:0]  erx;
      logic        eerr;
      int          rxv_seen;

      vecs.push_back('{0, 6'b011000, -1, 1'b0, 2'b00, 6'b011000, 1'b0, "pmz"});
      vecs.push_back('{0, 6'b010101,  1, 1'b0, 2'b00, 6'b010001, 1'b1, "bad_second"});
      vecs.push_back('{0, 6'b011000, -1, 1'b0, 2'b00, 6'b011000, 1'b0, "clean_after_err"});
      vecs.push_back('{0, 6'b110111, -1, 1'b0, 2'b00, 6'b000100, 1'b0, "invalid_tx"});
      vecs.push_back('{0, 6'b101010, -1, 1'b0, 2'b00, 6'b101010, 1'b0, "all_minus"});
      vecs.push_back('{0, 6'b000000,  2, 1'b0, 2'b00, 6'b000000, 1'b1, "bad_last"});
      vecs.push_back('{1, 6'b000001, -1, 1'b1, 2'b10, 6'b000010, 1'b0, "t1_plus"});
      vecs.push_back('{1, 6'b000010, -1, 1'b1, 2'b11, 6'b000000, 1'b1, "t1_invalid_rx"});

      rst_n = 1'b0;
      bad = 1'b0;
      use_const = 1'b0;
      const_miso = 2'b00;
      set_tx(0, 1'b0, 6'd0);
      set_tx(1, 1'b0, 6'd0);
      repeat (3) @(negedge clk);
      check("reset_dut0", {21'd0, rdy0, rxv0, rxe0, rx0, cs0, sck0, mosi0}, 32'h010);
      check("reset_dut1", {25'd0, rdy1, rxv1, rxe1, rx1, cs1}, 32'h001);
      check("reset_dut1_lines", {28'd0, sck1, mosi1}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {30'd0, rdy0, rdy1}, 32'b11);

      foreach (vecs[i]) begin
         use_const  = vecs[i].uc;
         const_miso = vecs[i].cmiso;
         run_word(vecs[i].sel, vecs[i].tx, vecs[i].bad_k, vecs[i].exp_rx, vecs[i].exp_err,
                  1'b0, 6'd0, 1'b0, vecs[i].name, waited);
      end
      use_const = 1'b0;

      // Back-to-back words with valid held high through the first transfer.
      run_word(0, 6'b011001, -1, 6'b011001, 1'b0, 1'b1, 6'b100100, 1'b0, "hold_first", waited);
      run_word(0, 6'b100100, -1, 6'b100100, 1'b0, 1'b0, 6'd0, 1'b0, "hold_second", waited);
      check("hold_second_wait_cycles", 32'(waited), 32'd0);

      // Random words with loopback and optional invalid sample, busy-time noise on valid/data.
      for (int i = 0; i < 16; i++) begin
         r  = $urandom;
         w  = r[5:0];
         bk = int'($urandom_range(0, 3)) - 1;
         model_rx(3, w, bk, 1'b0, 2'b00, erx, eerr);
         run_word(0, w, bk, erx, eerr, 1'b0, 6'd0, 1'b1, "rand3", waited);
      end

      // Random single-trit words against a constant peripheral response.
      use_const = 1'b1;
      for (int i = 0; i < 8; i++) begin
         r          = $urandom;
         w          = {4'b0000, r[1:0]};
         const_miso = r[3:2];
         bk         = r[4] ? 0 : -1;
         model_rx(1, w, bk, 1'b1, const_miso, erx, eerr);
         run_word(1, w, bk, erx, eerr, 1'b0, 6'd0, 1'b1, "rand1", waited);
      end
      use_const = 1'b0;

      // One-cycle reset during the second trit's SETUP aborts the transfer.
      set_tx(0, 1'b1, 6'b010101);
      @(posedge clk);
      #1;
      set_tx(0, 1'b0, 6'd0);
      for (int n = 0; n <= 6; n++) @(negedge clk);
      check("pre_reset_sck", 32'(sck0), 32'b10);
      rst_n = 1'b0;
      #1;
      check("ready_low_in_reset", 32'(rdy0), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_lines", {27'd0, cs0, sck0, mosi0}, 32'h10);
      check("abort_rx", {24'd0, rxv0, rxe0, rx0}, 32'd0);
      check("abort_ready", 32'(rdy0), 32'd1);
      rxv_seen = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (rxv0) rxv_seen++;
      end
      check("abort_no_rx_valid", 32'(rxv_seen), 32'd0);
      run_word(0, 6'b011000, -1, 6'b011000, 1'b0, 1'b0, 6'd0, 1'b0, "post_abort", waited);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
